ghist_ckpt_ctrl: RTL and testbench

- Controller sequencing all writes into the TAGE circular global history buffer.
- Accepts speculative predictions from fetch and allocates one pointer checkpoint per in-flight conditional branch.
- Retires checkpoints at commit. On a misprediction, rewinds the history pointer and rewrites the corrected outcome.
- Drives a pointer-addressed history write port and publishes the speculative insertion pointer used for read rotation.

---
 rtl/ghist_ckpt_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ghist_ckpt_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ghist_ckpt_ctrl.sv
// Global-history write sequencer: per-branch pointer checkpoints, commit retire and mispredict rewind.
// Optional GHIST_CTRL_CHECK_EN adds simulation assertions and a sticky err flag.
module ghist_ckpt_ctrl #(
  parameter int unsigned GHIST_LEN  = 256,
  parameter int unsigned CKPT_DEPTH = 16,
  localparam int unsigned INDEX_W   = $clog2(GHIST_LEN),
  localparam int unsigned TAG_W     = $clog2(CKPT_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pred_valid,
  input  logic               pred_taken,
  output logic               pred_ready,
  output logic [TAG_W-1:0]   pred_tag,
  input  logic               commit_valid,
  input  logic               mis_valid,
  input  logic [TAG_W-1:0]   mis_tag,
  input  logic               mis_taken,
  output logic               hist_we,
  output logic               hist_wdata,
  output logic [INDEX_W-1:0] hist_wptr,
  output logic [INDEX_W-1:0] head_ptr,
  output logic [TAG_W:0]     inflight_cnt,
  output logic               busy
);

  localparam int unsigned CW = TAG_W + 1;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [CW-1:0]       ck_head;
  logic [CW-1:0]       ck_tail;
  logic [INDEX_W-1:0]  spec_ptr;
  logic [INDEX_W-1:0]  ckpt [CKPT_DEPTH];

  logic [CW-1:0]       ck_head_d;
  logic [CW-1:0]       ck_tail_d;
  logic [INDEX_W-1:0]  spec_ptr_d;
  logic                hist_we_d;
  logic                hist_wdata_d;
  logic [INDEX_W-1:0]  hist_wptr_d;
  logic                busy_d;

  logic [CW-1:0]       cnt;
  logic                full;
  logic                accept;
  logic                commit;
  logic [TAG_W-1:0]    mis_off;
  logic                mis_in_range;
  logic                mis_hit;
  logic [INDEX_W-1:0]  mis_ptr;

  // Occupancy and request qualification
  always_comb begin
    cnt          = ck_tail - ck_head;
    full         = (cnt == CW'(CKPT_DEPTH));
    pred_ready   = (state == ST_NORMAL) && !mis_valid && !full;
    pred_tag     = ck_tail[TAG_W-1:0];
    accept       = pred_valid && pred_ready;
    commit       = commit_valid && (cnt != '0);
    // Distance from the oldest slot; only slots younger than tail are live.
    mis_off      = mis_tag - ck_head[TAG_W-1:0];
    mis_in_range = (CW'(mis_off) < cnt);
    mis_hit      = mis_valid && mis_in_range;
    mis_ptr      = ckpt[mis_tag];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: recovery lasts one cycle and is re-entered on every accepted mispredict
  always_comb begin
    state_nxt = ST_NORMAL;
    case (state)
      ST_NORMAL:  if (mis_hit) state_nxt = ST_RECOVER;
      ST_RECOVER: if (mis_hit) state_nxt = ST_RECOVER;
      default:    state_nxt = ST_NORMAL;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    hist_we_d    = 1'b0;
    hist_wdata_d = hist_wdata;
    hist_wptr_d  = hist_wptr;
    busy_d       = (state_nxt == ST_RECOVER);
    ck_head_d    = ck_head + CW'(commit);
    ck_tail_d    = ck_tail;
    spec_ptr_d   = spec_ptr;
    if (mis_hit) begin
      hist_we_d    = 1'b1;
      hist_wdata_d = mis_taken;
      hist_wptr_d  = mis_ptr;
      spec_ptr_d   = mis_ptr + INDEX_W'(1);
      ck_tail_d    = ck_head + CW'(mis_off) + CW'(1);
    end else if (accept) begin
      hist_we_d    = 1'b1;
      hist_wdata_d = pred_taken;
      hist_wptr_d  = spec_ptr;
      spec_ptr_d   = spec_ptr + INDEX_W'(1);
      ck_tail_d    = ck_tail + CW'(1);
    end
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_head    <= '0;
      ck_tail    <= '0;
      spec_ptr   <= '0;
      hist_we    <= 1'b0;
      hist_wdata <= 1'b0;
      hist_wptr  <= '0;
      busy       <= 1'b0;
    end else begin
      ck_head    <= ck_head_d;
      ck_tail    <= ck_tail_d;
      spec_ptr   <= spec_ptr_d;
      hist_we    <= hist_we_d;
      hist_wdata <= hist_wdata_d;
      hist_wptr  <= hist_wptr_d;
      busy       <= busy_d;
    end
  end

  // Checkpoint RAM; a slot is always written before it can be named in range
  always_ff @(posedge clk) begin
    if (accept) begin
      ckpt[ck_tail[TAG_W-1:0]] <= spec_ptr;
    end
  end

  assign head_ptr     = spec_ptr;
  assign inflight_cnt = cnt;

`ifdef GHIST_CTRL_CHECK_EN
  logic err;
  logic prev_stall;
  logic prev_taken;
  logic stall_viol;
  logic bad_commit;
  logic bad_mis;
  logic bad_cnt;

  always_comb begin
    bad_commit = commit_valid && (cnt == '0);
    bad_mis    = mis_valid && !mis_in_range;
    stall_viol = prev_stall && (!pred_valid || (pred_taken != prev_taken));
    bad_cnt    = (cnt > CW'(CKPT_DEPTH));
  end

  // Sticky protocol error flag plus stall tracking for the stability rule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err        <= 1'b0;
      prev_stall <= 1'b0;
      prev_taken <= 1'b0;
    end else begin
      if (bad_commit || bad_mis || stall_viol || bad_cnt) err <= 1'b1;
      prev_stall <= pred_valid && !pred_ready;
      prev_taken <= pred_taken;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!bad_commit) else $error("ghist_ckpt_ctrl: commit while empty");
      assert (!bad_mis)    else $error("ghist_ckpt_ctrl: mis_tag not in flight");
      assert (!stall_viol) else $error("ghist_ckpt_ctrl: stalled prediction not held");
      assert (!bad_cnt)    else $error("ghist_ckpt_ctrl: inflight count overflow");
    end
  end
`endif

endmodule

// File: tb/tb_ghist_ckpt_ctrl.sv
// Self-checking bench for ghist_ckpt_ctrl: directed scenarios plus a randomized run against a queue model.
module tb_ghist_ckpt_ctrl;

  localparam int L = 256;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pred_valid = 1'b0;
  logic       pred_taken = 1'b0;
  logic       pred_ready;
  logic [3:0] pred_tag;
  logic       commit_valid = 1'b0;
  logic       mis_valid = 1'b0;
  logic [3:0] mis_tag = 4'd0;
  logic       mis_taken = 1'b0;
  logic       hist_we;
  logic       hist_wdata;
  logic [7:0] hist_wptr;
  logic [7:0] head_ptr;
  logic [4:0] inflight_cnt;
  logic       busy;

  int tests = 0;
  int fails = 0;

  ghist_ckpt_ctrl #(.GHIST_LEN(L), .CKPT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready), .pred_tag(pred_tag),
    .commit_valid(commit_valid), .mis_valid(mis_valid), .mis_tag(mis_tag), .mis_taken(mis_taken),
    .hist_we(hist_we), .hist_wdata(hist_wdata), .hist_wptr(hist_wptr),
    .head_ptr(head_ptr), .inflight_cnt(inflight_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: queue of checkpointed pointers, oldest first
  int q[$];
  int head_idx;
  int spec;
  bit rec;
  int exp_we, exp_wdata, exp_wptr, exp_busy;
  int exp_ready, exp_tag;
  int obs_ready, obs_tag;

  function automatic void model_reset();
    q.delete();
    head_idx = 0; spec = 0; rec = 0;
    exp_we = 0; exp_wdata = 0; exp_wptr = 0; exp_busy = 0;
  endfunction

  // Drive one cycle of inputs, sample combinational outputs, advance the model, land #1 after the edge
  task automatic tick(input bit pv, input bit pt, input bit cv, input bit mv, input int mtag, input bit mt);
    int cnt, idx, p;
    bit acc, mis_ok;
    @(negedge clk);
    pred_valid = pv; pred_taken = pt; commit_valid = cv;
    mis_valid = mv; mis_tag = 4'(mtag); mis_taken = mt;
    #1;
    obs_ready = int'(pred_ready);
    obs_tag   = int'(pred_tag);
    cnt       = q.size();
    exp_ready = (!rec && !mv && cnt != D) ? 1 : 0;
    exp_tag   = (head_idx + cnt) % D;
    acc       = pv && (exp_ready == 1);
    idx       = ((mtag % D) - (head_idx % D) + D) % D;
    mis_ok    = mv && (idx < cnt);
    exp_we    = 0;
    if (mis_ok) begin
      p = q[idx];
      while (q.size() > idx + 1) void'(q.pop_back());
      spec = (p + 1) % L;
      exp_we = 1; exp_wdata = int'(mt); exp_wptr = p;
    end else if (acc) begin
      q.push_back(spec);
      exp_we = 1; exp_wdata = int'(pt); exp_wptr = spec;
      spec = (spec + 1) % L;
    end
    if (cv && cnt != 0) begin
      void'(q.pop_front());
      head_idx++;
    end
    rec = mis_ok;
    exp_busy = mis_ok ? 1 : 0;
    @(posedge clk);
    #1;
    pred_valid = 1'b0; commit_valid = 1'b0; mis_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pred_valid = 1'b0; commit_valid = 1'b0; mis_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (hist_we !== 1'b0) begin fails++; $display("FAIL reset_we got %0b exp 0", hist_we); end
    tests++; if (hist_wptr !== 8'd0 || hist_wdata !== 1'b0) begin fails++; $display("FAIL reset_wport got %0d/%0b exp 0/0", hist_wptr, hist_wdata); end
    tests++; if (head_ptr !== 8'd0) begin fails++; $display("FAIL reset_head got %0d exp 0", head_ptr); end
    tests++; if (inflight_cnt !== 5'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", inflight_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
    tests++; if (pred_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b exp 1", pred_ready); end
  endtask

  task automatic test_basic();
    bit dir[3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, dir[i], 0, 0, 0, 0);
      tests++; if (obs_tag != i || obs_ready != 1) begin fails++; $display("FAIL basic_tag%0d got %0d/%0d exp %0d/1", i, obs_tag, obs_ready, i); end
      tests++; if (hist_we !== 1'b1 || hist_wptr !== 8'(i) || hist_wdata !== dir[i]) begin
        fails++; $display("FAIL basic_write%0d got we=%0b ptr=%0d d=%0b exp 1/%0d/%0b", i, hist_we, hist_wptr, hist_wdata, i, dir[i]);
      end
    end
    tick(0, 0, 0, 0, 0, 0);
    tests++; if (hist_we !== 1'b0 || hist_wptr !== 8'd2 || hist_wdata !== 1'b1) begin fails++; $display("FAIL basic_pulse got we=%0b ptr=%0d d=%0b exp 0/2/1", hist_we, hist_wptr, hist_wdata); end
    tests++; if (head_ptr !== 8'd3 || inflight_cnt !== 5'd3) begin fails++; $display("FAIL basic_state got head=%0d cnt=%0d exp 3/3", head_ptr, inflight_cnt); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) tick(1, i[0], 0, 0, 0, 0);
    tests++; if (inflight_cnt !== 5'd16 || pred_ready !== 1'b0) begin fails++; $display("FAIL full_cnt got cnt=%0d rdy=%0b exp 16/0", inflight_cnt, pred_ready); end
    tick(1, 1, 0, 0, 0, 0);
    tests++; if (obs_ready != 0 || hist_we !== 1'b0 || inflight_cnt !== 5'd16) begin fails++; $display("FAIL full_block got rdy=%0d we=%0b cnt=%0d exp 0/0/16", obs_ready, hist_we, inflight_cnt); end
    tick(0, 0, 1, 0, 0, 0);
    tests++; if (inflight_cnt !== 5'd15 || pred_ready !== 1'b1) begin fails++; $display("FAIL full_commit got cnt=%0d rdy=%0b exp 15/1", inflight_cnt, pred_ready); end
    tick(1, 0, 0, 0, 0, 0);
    tests++; if (obs_ready != 1 || obs_tag != 0 || hist_wptr !== 8'd16) begin fails++; $display("FAIL full_wraptag got rdy=%0d tag=%0d ptr=%0d exp 1/0/16", obs_ready, obs_tag, hist_wptr); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 7, 1);
    tests++; if (hist_we !== 1'b1 || hist_wptr !== 8'd7 || hist_wdata !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL mis_write got we=%0b ptr=%0d d=%0b busy=%0b exp 1/7/1/1", hist_we, hist_wptr, hist_wdata, busy);
    end
    tests++; if (head_ptr !== 8'd8 || inflight_cnt !== 5'd3) begin fails++; $display("FAIL mis_state got head=%0d cnt=%0d exp 8/3", head_ptr, inflight_cnt); end
    tick(1, 1, 0, 0, 0, 0);
    tests++; if (obs_ready != 0 || hist_we !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mis_bubble got rdy=%0d we=%0b busy=%0b exp 0/0/0", obs_ready, hist_we, busy); end
    tick(1, 1, 0, 0, 0, 0);
    tests++; if (obs_ready != 1 || obs_tag != 8 || hist_wptr !== 8'd8) begin fails++; $display("FAIL mis_resume got rdy=%0d tag=%0d ptr=%0d exp 1/8/8", obs_ready, obs_tag, hist_wptr); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 254; i++) tick(1, 0, 1, 0, 0, 0);
    tests++; if (head_ptr !== 8'd255 || inflight_cnt !== 5'd1) begin fails++; $display("FAIL wrap_pre got head=%0d cnt=%0d exp 255/1", head_ptr, inflight_cnt); end
    tick(1, 1, 1, 0, 0, 0);
    tests++; if (hist_wptr !== 8'd255 || head_ptr !== 8'd0) begin fails++; $display("FAIL wrap_edge got ptr=%0d head=%0d exp 255/0", hist_wptr, head_ptr); end
    tick(1, 0, 0, 0, 0, 0);
    tests++; if (hist_we !== 1'b1 || hist_wptr !== 8'd0 || head_ptr !== 8'd1) begin fails++; $display("FAIL wrap_next got we=%0b ptr=%0d head=%0d exp 1/0/1", hist_we, hist_wptr, head_ptr); end
  endtask

  task automatic test_commit_mis();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 1, 1, 0, 0);
    tests++; if (obs_ready != 0) begin fails++; $display("FAIL cm_drop got rdy=%0d exp 0", obs_ready); end
    tests++; if (inflight_cnt !== 5'd0 || hist_we !== 1'b1 || hist_wptr !== 8'd0 || hist_wdata !== 1'b0) begin
      fails++; $display("FAIL cm_write got cnt=%0d we=%0b ptr=%0d d=%0b exp 0/1/0/0", inflight_cnt, hist_we, hist_wptr, hist_wdata);
    end
    tests++; if (head_ptr !== 8'd1 || busy !== 1'b1) begin fails++; $display("FAIL cm_state got head=%0d busy=%0b exp 1/1", head_ptr, busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 4, 1);
    tests++; if (hist_wptr !== 8'd4 || inflight_cnt !== 5'd5) begin fails++; $display("FAIL b2b_first got ptr=%0d cnt=%0d exp 4/5", hist_wptr, inflight_cnt); end
    tick(0, 0, 0, 1, 1, 0);
    tests++; if (hist_we !== 1'b1 || hist_wptr !== 8'd1 || hist_wdata !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL b2b_second got we=%0b ptr=%0d d=%0b busy=%0b exp 1/1/0/1", hist_we, hist_wptr, hist_wdata, busy);
    end
    tests++; if (head_ptr !== 8'd2 || inflight_cnt !== 5'd2) begin fails++; $display("FAIL b2b_state got head=%0d cnt=%0d exp 2/2", head_ptr, inflight_cnt); end
    tick(1, 0, 0, 0, 0, 0);
    tests++; if (obs_ready != 0 || busy !== 1'b0) begin fails++; $display("FAIL b2b_bubble got rdy=%0d busy=%0b exp 0/0", obs_ready, busy); end
  endtask

  task automatic test_ignored();
    do_reset();
    tick(0, 0, 1, 0, 0, 0);
    tests++; if (inflight_cnt !== 5'd0 || hist_we !== 1'b0) begin fails++; $display("FAIL ign_commit got cnt=%0d we=%0b exp 0/0", inflight_cnt, hist_we); end
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 5, 1);
    tests++; if (hist_we !== 1'b0 || busy !== 1'b0 || inflight_cnt !== 5'd2 || head_ptr !== 8'd2) begin
      fails++; $display("FAIL ign_mis got we=%0b busy=%0b cnt=%0d head=%0d exp 0/0/2/2", hist_we, busy, inflight_cnt, head_ptr);
    end
  endtask

  task automatic test_recover_reset();
    do_reset();
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (hist_we !== 1'b0 || busy !== 1'b0 || inflight_cnt !== 5'd0 || head_ptr !== 8'd0) begin
      fails++; $display("FAIL rr_async got we=%0b busy=%0b cnt=%0d head=%0d exp 0/0/0/0", hist_we, busy, inflight_cnt, head_ptr);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (pred_ready !== 1'b1) begin fails++; $display("FAIL rr_ready got %0b exp 1", pred_ready); end
  endtask

  task automatic test_random();
    int pick;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      pick = (q.size() > 0 && $urandom_range(1, 0) == 1) ? ((head_idx + int'($urandom_range(q.size() - 1, 0))) % D)
                                                         : int'($urandom_range(D - 1, 0));
      tick($urandom_range(9, 0) < 6, $urandom_range(1, 0) == 1, $urandom_range(9, 0) < 3,
           $urandom_range(99, 0) < 8, pick, $urandom_range(1, 0) == 1);
      tests++;
      if (obs_ready != exp_ready || (exp_ready == 1 && obs_tag != exp_tag) ||
          int'(hist_we) != exp_we || int'(hist_wdata) != exp_wdata || int'(hist_wptr) != exp_wptr ||
          int'(head_ptr) != spec || int'(inflight_cnt) != q.size() || int'(busy) != exp_busy) begin
        fails++;
        $display("FAIL rand_cycle%0d got rdy=%0d tag=%0d we=%0b d=%0b ptr=%0d head=%0d cnt=%0d busy=%0b exp rdy=%0d tag=%0d we=%0d d=%0d ptr=%0d head=%0d cnt=%0d busy=%0d",
                 n, obs_ready, obs_tag, hist_we, hist_wdata, hist_wptr, head_ptr, inflight_cnt, busy,
                 exp_ready, exp_tag, exp_we, exp_wdata, exp_wptr, spec, q.size(), exp_busy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_mispredict();
    test_wrap();
    test_commit_mis();
    test_back_to_back();
    test_ignored();
    test_recover_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
